// File: rtl/decode_stage_hz.sv
// ============================================================================
// Module   : decode_stage_hz
// Purpose  : ID stage with control decode, bypassed register file, load-use
//            hazard detection and a saturating stall counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_stage_hz #(
    parameter int DATA_W    = 32,
    parameter int CNT_W     = 16,
    parameter bit HAZARD_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       if_id_instr,
    input  logic [DATA_W-1:0] if_id_npc,
    input  logic              if_id_valid,
    input  logic [4:0]        mem_wb_rd,
    input  logic              mem_wb_regwrite,
    input  logic [DATA_W-1:0] wb_writedata,
    input  logic              flush,
    output logic [1:0]        wb_ctlout,
    output logic [2:0]        m_ctlout,
    output logic              regdst,
    output logic              alusrc,
    output logic [1:0]        aluop,
    output logic [DATA_W-1:0] npcout,
    output logic [DATA_W-1:0] rdata1out,
    output logic [DATA_W-1:0] rdata2out,
    output logic [DATA_W-1:0] s_extendout,
    output logic [4:0]        instrout_2016,
    output logic [4:0]        instrout_1511,
    output logic              id_ex_valid,
    output logic              pc_write,
    output logic              if_id_write,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [5:0] c_op_rtype = 6'h00;
    localparam logic [5:0] c_op_lw    = 6'h23;
    localparam logic [5:0] c_op_sw    = 6'h2B;
    localparam logic [5:0] c_op_beq   = 6'h04;

    logic [DATA_W-1:0] regs_q [32];
    logic [DATA_W-1:0] regs_d [32];

    logic [1:0]        wb_ctl_q, wb_ctl_d;
    logic [2:0]        m_ctl_q, m_ctl_d;
    logic              regdst_q, regdst_d;
    logic              alusrc_q, alusrc_d;
    logic [1:0]        aluop_q, aluop_d;
    logic [DATA_W-1:0] npc_q, npc_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic [DATA_W-1:0] rdata2_q, rdata2_d;
    logic [DATA_W-1:0] sext_q, sext_d;
    logic [4:0]        rt_q, rt_d;
    logic [4:0]        rd_q, rd_d;
    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic [5:0]        w_opcode;
    logic [4:0]        w_rs, w_rt;
    logic [1:0]        w_wb_dec;
    logic [2:0]        w_m_dec;
    logic              w_regdst_dec, w_alusrc_dec;
    logic [1:0]        w_aluop_dec;
    logic [DATA_W-1:0] w_rs_data, w_rt_data;
    logic              w_hz;
    logic              w_bubble;

    assign w_opcode = if_id_instr[31:26];
    assign w_rs     = if_id_instr[25:21];
    assign w_rt     = if_id_instr[20:16];

    always_comb begin
        w_wb_dec     = 2'b00;
        w_m_dec      = 3'b000;
        w_regdst_dec = 1'b0;
        w_aluop_dec  = 2'b00;
        w_alusrc_dec = 1'b0;
        case (w_opcode)
            c_op_rtype: begin
                w_regdst_dec = 1'b1;
                w_aluop_dec  = 2'b10;
                w_wb_dec     = 2'b10;
            end
            c_op_lw: begin
                w_alusrc_dec = 1'b1;
                w_m_dec      = 3'b010;
                w_wb_dec     = 2'b11;
            end
            c_op_sw: begin
                w_alusrc_dec = 1'b1;
                w_m_dec      = 3'b001;
            end
            c_op_beq: begin
                w_aluop_dec  = 2'b01;
                w_m_dec      = 3'b100;
            end
            default: ;
        endcase
    end

    // Writeback in the same cycle is forwarded so ID never sees stale data.
    always_comb begin
        w_rs_data = regs_q[w_rs];
        w_rt_data = regs_q[w_rt];
        if (mem_wb_regwrite && (mem_wb_rd != 5'd0) && (mem_wb_rd == w_rs))
            w_rs_data = wb_writedata;
        if (mem_wb_regwrite && (mem_wb_rd != 5'd0) && (mem_wb_rd == w_rt))
            w_rt_data = wb_writedata;
        if (w_rs == 5'd0)
            w_rs_data = '0;
        if (w_rt == 5'd0)
            w_rt_data = '0;
    end

    assign w_hz = HAZARD_EN && if_id_valid && !flush && valid_q && m_ctl_q[1]
                  && (rt_q != 5'd0) && ((rt_q == w_rs) || (rt_q == w_rt));
    assign w_bubble = flush || w_hz || !if_id_valid;

    always_comb begin
        regs_d = regs_q;
        if (mem_wb_regwrite && (mem_wb_rd != 5'd0))
            regs_d[mem_wb_rd] = wb_writedata;

        wb_ctl_d = '0;
        m_ctl_d  = '0;
        regdst_d = 1'b0;
        alusrc_d = 1'b0;
        aluop_d  = '0;
        npc_d    = '0;
        rdata1_d = '0;
        rdata2_d = '0;
        sext_d   = '0;
        rt_d     = '0;
        rd_d     = '0;
        valid_d  = 1'b0;
        if (!w_bubble) begin
            wb_ctl_d = w_wb_dec;
            m_ctl_d  = w_m_dec;
            regdst_d = w_regdst_dec;
            alusrc_d = w_alusrc_dec;
            aluop_d  = w_aluop_dec;
            npc_d    = if_id_npc;
            rdata1_d = w_rs_data;
            rdata2_d = w_rt_data;
            sext_d   = {{(DATA_W-16){if_id_instr[15]}}, if_id_instr[15:0]};
            rt_d     = if_id_instr[20:16];
            rd_d     = if_id_instr[15:11];
            valid_d  = 1'b1;
        end

        stall_cnt_d = stall_cnt_q;
        if (w_hz && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q      <= '{default: '0};
            wb_ctl_q    <= '0;
            m_ctl_q     <= '0;
            regdst_q    <= 1'b0;
            alusrc_q    <= 1'b0;
            aluop_q     <= '0;
            npc_q       <= '0;
            rdata1_q    <= '0;
            rdata2_q    <= '0;
            sext_q      <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            valid_q     <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            regs_q      <= regs_d;
            wb_ctl_q    <= wb_ctl_d;
            m_ctl_q     <= m_ctl_d;
            regdst_q    <= regdst_d;
            alusrc_q    <= alusrc_d;
            aluop_q     <= aluop_d;
            npc_q       <= npc_d;
            rdata1_q    <= rdata1_d;
            rdata2_q    <= rdata2_d;
            sext_q      <= sext_d;
            rt_q        <= rt_d;
            rd_q        <= rd_d;
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign wb_ctlout     = wb_ctl_q;
    assign m_ctlout      = m_ctl_q;
    assign regdst        = regdst_q;
    assign alusrc        = alusrc_q;
    assign aluop         = aluop_q;
    assign npcout        = npc_q;
    assign rdata1out     = rdata1_q;
    assign rdata2out     = rdata2_q;
    assign s_extendout   = sext_q;
    assign instrout_2016 = rt_q;
    assign instrout_1511 = rd_q;
    assign id_ex_valid   = valid_q;
    assign pc_write      = ~w_hz;
    assign if_id_write   = ~w_hz;
    assign stall_cnt     = stall_cnt_q;

endmodule

`default_nettype wire
